vector_frame_sched: RTL and testbench

//  Frame scheduler for the vector display pipeline (vector_manage + linedraw).

---
 rtl/vector_frame_sched.sv | 132 +++++++++++++
 tb/tb_vector_frame_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_frame_sched.sv
// Frame scheduler for the vector display: one pass per refresh period, double-buffer bank swap between passes.
// Optional pass watchdog enabled by defining VFS_WATCHDOG_EN.
module vector_frame_sched #(
  parameter int unsigned FRAME_TICKS = 65536,
  parameter int unsigned CNT_WIDTH   = 17,
  parameter int unsigned WDOG_TICKS  = 60000
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_frame_done,
  input  logic draw_frame_end,
  input  logic draw_busy,
  output logic frame_start,
  output logic disp_enable,
  output logic rd_bank,
  output logic wr_bank,
  output logic swap_ack,
  output logic overrun,
  output logic wdog_err
);

  localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(FRAME_TICKS - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_START = 2'd1,
    ST_DRAW  = 2'd2,
    ST_SWAP  = 2'd3
  } state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 tick_q;
  logic                 pend_swap_q;
  logic                 pend_tick_q;
`ifdef VFS_WATCHDOG_EN
  localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(WDOG_TICKS - 1);
  logic [CNT_WIDTH-1:0] wd_q;
`endif

  // draw_busy is status only: enable changes are driven solely by pass boundaries
  logic unused_ok;
`ifdef VFS_WATCHDOG_EN
  assign unused_ok = draw_busy;
`else
  assign unused_ok = ^{draw_busy, CNT_WIDTH'(WDOG_TICKS)};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_WAIT;
      cnt_q       <= RELOAD;
      tick_q      <= 1'b0;
      pend_swap_q <= 1'b0;
      pend_tick_q <= 1'b0;
      frame_start <= 1'b0;
      disp_enable <= 1'b0;
      rd_bank     <= 1'b0;
      wr_bank     <= 1'b1;
      swap_ack    <= 1'b0;
      overrun     <= 1'b0;
      wdog_err    <= 1'b0;
`ifdef VFS_WATCHDOG_EN
      wd_q        <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;

      // Registered tick keeps the first tick exactly FRAME_TICKS cycles after release
      tick_q <= (cnt_q == '0);
      cnt_q  <= (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;

      // A second completion before the swap, or one during the swap cycle, is dropped
      if (wr_frame_done && !pend_swap_q && (state_q != ST_SWAP)) begin
        pend_swap_q <= 1'b1;
      end

      case (state_q)
        ST_WAIT: begin
          if (tick_q || pend_tick_q) begin
            state_q     <= ST_START;
            frame_start <= 1'b1;
            disp_enable <= 1'b1;
            pend_tick_q <= 1'b0;
`ifdef VFS_WATCHDOG_EN
            wd_q        <= '0;
`endif
          end
        end
        ST_START: begin
          state_q <= ST_DRAW;
`ifdef VFS_WATCHDOG_EN
          wd_q    <= wd_q + 1'b1;
`endif
        end
        ST_DRAW: begin
          if (tick_q) begin
            overrun     <= 1'b1;
            pend_tick_q <= 1'b1;
          end
          if (draw_frame_end) begin
            disp_enable <= 1'b0;
            state_q     <= pend_swap_q ? ST_SWAP : ST_WAIT;
          end
`ifdef VFS_WATCHDOG_EN
          else if (wd_q == WDOG_LAST) begin
            // Abort keeps the pending swap for the next completed pass
            disp_enable <= 1'b0;
            wdog_err    <= 1'b1;
            state_q     <= ST_WAIT;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        ST_SWAP: begin
          rd_bank     <= ~rd_bank;
          wr_bank     <= rd_bank;
          swap_ack    <= 1'b1;
          pend_swap_q <= 1'b0;
          state_q     <= ST_WAIT;
          if (tick_q) begin
            pend_tick_q <= 1'b1;
          end
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_frame_sched.sv
// Directed bench for vector_frame_sched (FRAME_TICKS=100, WDOG_TICKS=50).
// Cycle n = state sampled 1ns after the n-th rising edge following reset release.
module tb_vector_frame_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_frame_done = 1'b0;
  logic draw_frame_end = 1'b0;
  logic draw_busy = 1'b0;
  logic frame_start, disp_enable, rd_bank, wr_bank, swap_ack, overrun, wdog_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int swap_cnt = 0;
  int fs_cnt   = 0;

  vector_frame_sched #(
    .FRAME_TICKS(100),
    .CNT_WIDTH  (17),
    .WDOG_TICKS (50)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_frame_done (wr_frame_done),
    .draw_frame_end(draw_frame_end),
    .draw_busy     (draw_busy),
    .frame_start   (frame_start),
    .disp_enable   (disp_enable),
    .rd_bank       (rd_bank),
    .wr_bank       (wr_bank),
    .swap_ack      (swap_ack),
    .overrun       (overrun),
    .wdog_err      (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (swap_ack === 1'b1) swap_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Drive a one-cycle pulse during the current cycle; it is sampled on the next edge
  task automatic pulse_wfd();
    wr_frame_done = 1'b1;
    step();
    wr_frame_done = 1'b0;
  endtask

  task automatic pulse_dfe();
    draw_frame_end = 1'b1;
    step();
    draw_frame_end = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wr_frame_done = 1'b0;
    draw_frame_end = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    cyc = 0;
    swap_cnt = 0;
    fs_cnt = 0;
  endtask

  initial begin
    // 1: reset state, first pass, pass end without swap
    do_reset();
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_disp", 32'(disp_enable), 32'd0);
    chk("rst_rd", 32'(rd_bank), 32'd0);
    chk("rst_wr", 32'(wr_bank), 32'd1);
    chk("rst_ack", 32'(swap_ack), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_wdog", 32'(wdog_err), 32'd0);
    run_to(100);
    chk("s1_fs_100", 32'(frame_start), 32'd0);
    chk("s1_disp_100", 32'(disp_enable), 32'd0);
    run_to(101);
    chk("s1_fs_101", 32'(frame_start), 32'd1);
    chk("s1_disp_101", 32'(disp_enable), 32'd1);
    run_to(102);
    chk("s1_fs_102", 32'(frame_start), 32'd0);
    chk("s1_disp_102", 32'(disp_enable), 32'd1);
    run_to(121);
    pulse_dfe();
    chk("s1_disp_122", 32'(disp_enable), 32'd0);
    chk("s1_rd_122", 32'(rd_bank), 32'd0);
    run_to(200);
    chk("s1_fs_count", 32'(fs_cnt), 32'd1);
    chk("s1_noswap", 32'(swap_cnt), 32'd0);
    run_to(201);
    chk("s1_fs_201", 32'(frame_start), 32'd1);

    // 2: pending swap completes two cycles after pass end
    do_reset();
    run_to(10);
    pulse_wfd();
    run_to(130);
    pulse_dfe();
    chk("s2_disp_131", 32'(disp_enable), 32'd0);
    chk("s2_ack_131", 32'(swap_ack), 32'd0);
    chk("s2_rd_131", 32'(rd_bank), 32'd0);
    step();
    chk("s2_ack_132", 32'(swap_ack), 32'd1);
    chk("s2_rd_132", 32'(rd_bank), 32'd1);
    chk("s2_wr_132", 32'(wr_bank), 32'd0);
    step();
    chk("s2_ack_133", 32'(swap_ack), 32'd0);
    chk("s2_rd_133", 32'(rd_bank), 32'd1);

`ifndef VFS_WATCHDOG_EN
    // 3: pass longer than the refresh period
    do_reset();
    run_to(200);
    chk("s3_ovr_200", 32'(overrun), 32'd0);
    step();
    chk("s3_ovr_201", 32'(overrun), 32'd1);
    chk("s3_disp_201", 32'(disp_enable), 32'd1);
    chk("s3_fs_201", 32'(frame_start), 32'd0);
    run_to(250);
    pulse_dfe();
    chk("s3_disp_251", 32'(disp_enable), 32'd0);
    chk("s3_fs_251", 32'(frame_start), 32'd0);
    step();
    chk("s3_fs_252", 32'(frame_start), 32'd1);
    chk("s3_disp_252", 32'(disp_enable), 32'd1);
    chk("s3_ovr_252", 32'(overrun), 32'd1);
    chk("s3_wdog_252", 32'(wdog_err), 32'd0);
`endif

    // 4: duplicate writer completion and stray draw_frame_end in WAIT
    do_reset();
    run_to(10);
    pulse_wfd();
    run_to(20);
    pulse_wfd();
    run_to(50);
    pulse_dfe();
    run_to(60);
    chk("s4_idle_end_ignored", 32'(swap_cnt), 32'd0);
    chk("s4_idle_disp", 32'(disp_enable), 32'd0);
    run_to(130);
    pulse_dfe();
    run_to(140);
    chk("s4_one_swap", 32'(swap_cnt), 32'd1);
    chk("s4_rd_140", 32'(rd_bank), 32'd1);
    run_to(230);
    pulse_dfe();
    run_to(240);
    chk("s4_still_one_swap", 32'(swap_cnt), 32'd1);
    chk("s4_rd_240", 32'(rd_bank), 32'd1);
    chk("s4_wr_240", 32'(wr_bank), 32'd0);

`ifndef VFS_WATCHDOG_EN
    // 5: reset in the middle of an overrunning pass with a pending swap
    do_reset();
    run_to(10);
    pulse_wfd();
    run_to(130);
    pulse_dfe();
    run_to(250);
    pulse_wfd();
    run_to(301);
    chk("s5_ovr_301", 32'(overrun), 32'd1);
    chk("s5_rd_301", 32'(rd_bank), 32'd1);
    run_to(320);
    rst = 1'b0;
    step();
    chk("s5_rst_disp", 32'(disp_enable), 32'd0);
    chk("s5_rst_rd", 32'(rd_bank), 32'd0);
    chk("s5_rst_wr", 32'(wr_bank), 32'd1);
    chk("s5_rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b1;
    cyc = 0;
    swap_cnt = 0;
    fs_cnt = 0;
    run_to(100);
    chk("s5_fs_100", 32'(frame_start), 32'd0);
    run_to(101);
    chk("s5_fs_101", 32'(frame_start), 32'd1);
    run_to(121);
    pulse_dfe();
    step();
    chk("s5_pend_cleared_ack", 32'(swap_cnt), 32'd0);
    chk("s5_pend_cleared_rd", 32'(rd_bank), 32'd0);
`else
    // 6: watchdog abort without pass end
    do_reset();
    run_to(10);
    pulse_wfd();
    run_to(101);
    chk("s6_fs_101", 32'(frame_start), 32'd1);
    run_to(150);
    chk("s6_disp_150", 32'(disp_enable), 32'd1);
    chk("s6_wdog_150", 32'(wdog_err), 32'd0);
    step();
    chk("s6_disp_151", 32'(disp_enable), 32'd0);
    chk("s6_wdog_151", 32'(wdog_err), 32'd1);
    run_to(200);
    chk("s6_noswap", 32'(swap_cnt), 32'd0);
    chk("s6_rd_200", 32'(rd_bank), 32'd0);
    run_to(201);
    chk("s6_fs_201", 32'(frame_start), 32'd1);
    chk("s6_wdog_sticky", 32'(wdog_err), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
